// File: rtl/baud_tick_gen.sv
// Fractional-N baud tick generator: phase accumulator producing oversample, mid-bit and
// bit ticks, with a runtime increment that only takes effect at bit boundaries.
module baud_tick_gen #(
  parameter int unsigned CLK_FREQ    = 10_000_000,
  parameter int unsigned BAUD        = 115200,
  parameter int unsigned OVERSAMPLE  = 16,
  parameter int unsigned ACC_WIDTH   = 16,
  parameter logic [ACC_WIDTH-1:0] INC_DEFAULT = ACC_WIDTH'(
    ((64'(BAUD) * 64'(OVERSAMPLE) << ACC_WIDTH) + 64'(CLK_FREQ) / 64'd2) / 64'(CLK_FREQ))
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 restart,
  input  logic                 inc_load,
  input  logic [ACC_WIDTH-1:0] inc_value,
  output logic                 os_tick,
  output logic                 mid_tick,
  output logic                 bit_tick,
  output logic                 busy,
  output logic                 inc_pending,
  output logic [ACC_WIDTH-1:0] inc_active
);

  localparam int OS_CNT_W = $clog2(OVERSAMPLE);
  localparam logic [OS_CNT_W-1:0] OS_LAST = OS_CNT_W'(OVERSAMPLE - 1);
  localparam logic [OS_CNT_W-1:0] OS_MID  = OS_CNT_W'(OVERSAMPLE / 2 - 1);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                state_reg, state_next;
  logic [ACC_WIDTH-1:0]  acc_reg, acc_next;
  logic [OS_CNT_W-1:0]   os_cnt_reg, os_cnt_next;
  logic                  os_tick_reg, os_tick_next;
  logic                  mid_tick_reg, mid_tick_next;
  logic                  bit_tick_reg, bit_tick_next;
  logic [ACC_WIDTH-1:0]  inc_active_reg, inc_active_next;
  logic [ACC_WIDTH-1:0]  pend_val_reg, pend_val_next;
  logic                  pend_reg, pend_next;

  logic [ACC_WIDTH:0]    sum;
  logic                  carry;
  logic                  os_at_last;
  logic                  os_at_mid;

  assign sum        = {1'b0, acc_reg} + {1'b0, inc_active_reg};
  assign carry      = sum[ACC_WIDTH];
  assign os_at_last = (os_cnt_reg == OS_LAST);
  assign os_at_mid  = (os_cnt_reg == OS_MID);

  always_comb begin
    state_next      = state_reg;
    acc_next        = '0;
    os_cnt_next     = '0;
    os_tick_next    = 1'b0;
    mid_tick_next   = 1'b0;
    bit_tick_next   = 1'b0;
    inc_active_next = inc_active_reg;
    pend_val_next   = pend_val_reg;
    pend_next       = pend_reg;

    if (restart || state_reg == ST_IDLE) begin
      // Phase is realigned here, so a new increment can take effect immediately.
      state_next = en ? ST_RUN : ST_IDLE;
      if (inc_load) begin
        inc_active_next = inc_value;
        pend_next       = 1'b0;
      end else if (pend_reg) begin
        inc_active_next = pend_val_reg;
        pend_next       = 1'b0;
      end
    end else if (!en) begin
      // Partial bit is thrown away; a load here is kept for the idle edge to apply.
      state_next = ST_IDLE;
      if (inc_load) begin
        pend_val_next = inc_value;
        pend_next     = 1'b1;
      end
    end else begin
      acc_next      = sum[ACC_WIDTH-1:0];
      os_tick_next  = carry;
      mid_tick_next = carry & os_at_mid;
      bit_tick_next = carry & os_at_last;

      if (carry) begin
        os_cnt_next = os_at_last ? '0 : os_cnt_reg + OS_CNT_W'(1);
      end else begin
        os_cnt_next = os_cnt_reg;
      end

      // Swap increments only on the bit boundary; a same-edge load queues behind it.
      if (bit_tick_next && pend_reg) begin
        inc_active_next = pend_val_reg;
        pend_next       = 1'b0;
      end
      if (inc_load) begin
        pend_val_next = inc_value;
        pend_next     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      acc_reg        <= '0;
      os_cnt_reg     <= '0;
      os_tick_reg    <= 1'b0;
      mid_tick_reg   <= 1'b0;
      bit_tick_reg   <= 1'b0;
      inc_active_reg <= INC_DEFAULT;
      pend_val_reg   <= '0;
      pend_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      acc_reg        <= acc_next;
      os_cnt_reg     <= os_cnt_next;
      os_tick_reg    <= os_tick_next;
      mid_tick_reg   <= mid_tick_next;
      bit_tick_reg   <= bit_tick_next;
      inc_active_reg <= inc_active_next;
      pend_val_reg   <= pend_val_next;
      pend_reg       <= pend_next;
    end
  end

  assign os_tick     = os_tick_reg;
  assign mid_tick    = mid_tick_reg;
  assign bit_tick    = bit_tick_reg;
  assign busy        = (state_reg == ST_RUN);
  assign inc_pending = pend_reg;
  assign inc_active  = inc_active_reg;

endmodule
